// File: rtl/pwm_medidor.sv
// PWM duty/period meter: synchronizes pwm_in, measures high time and period in clk cycles,
// and derives duty = floor(H*2^R/P) with a serial restoring divider running alongside measurement.
module pwm_medidor #(
    parameter int unsigned R = 6,
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [R-1:0] duty,
    output logic [W-1:0] high_count,
    output logic [W-1:0] period_count,
    output logic         valid,
    output logic         stuck
);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW
    } meas_state_e;

    typedef enum logic {
        DIV_IDLE,
        DIV_RUN
    } div_state_e;

    localparam int unsigned CW = $clog2(R + 1);
    localparam logic [W-1:0] TMAX = '1;
    localparam logic [W-1:0] TPRE = {{(W-1){1'b1}}, 1'b0};
    localparam logic [CW-1:0] DLAST = CW'(R);

    // Synchronizer and edge detection
    logic sync1_q;
    logic s_q;
    logic s_prev_q;

    // Measurement state
    meas_state_e state_q;
    logic [W-1:0] hcnt_q;
    logic [W-1:0] pcnt_q;
    logic [W-1:0] tcnt_q;

    // Divider state
    div_state_e  div_state_q;
    logic [W:0]   rem_q;
    logic [W-1:0] div_p_q;
    logic [W-1:0] h_lat_q;
    logic [W-1:0] p_lat_q;
    logic [R-1:0] quot_q;
    logic [CW-1:0] dcnt_q;

    // Registered outputs
    logic [R-1:0] duty_q;
    logic [W-1:0] high_count_q;
    logic [W-1:0] period_count_q;
    logic         valid_q;
    logic         stuck_q;

    logic rise;
    logic fall;
    logic timeout;
    logic latch;

    logic [W:0] rem_sh;
    logic       qbit;
    logic [W:0] rem_d;

    always_comb begin
        rise    = s_q & ~s_prev_q;
        fall    = ~s_q & s_prev_q;
        // A rise on the very cycle the counter would saturate wins over the timeout.
        timeout = ~rise & (tcnt_q == TPRE);
        latch   = (state_q == MEAS_LOW) & rise;
    end

    always_comb begin
        rem_sh = rem_q << 1;
        qbit   = (rem_sh >= {1'b0, div_p_q});
        rem_d  = qbit ? (rem_sh - {1'b0, div_p_q}) : rem_sh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= pwm_in;
            s_q      <= sync1_q;
            s_prev_q <= s_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_RISE;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            if (rise) begin
                tcnt_q <= '0;
            end else if (tcnt_q != TMAX) begin
                tcnt_q <= tcnt_q + W'(1);
            end

            if (timeout) begin
                state_q <= WAIT_RISE;
            end else begin
                case (state_q)
                    WAIT_RISE: begin
                        if (rise) begin
                            hcnt_q  <= W'(1);
                            pcnt_q  <= W'(1);
                            state_q <= MEAS_HIGH;
                        end
                    end
                    MEAS_HIGH: begin
                        if (fall) begin
                            pcnt_q  <= pcnt_q + W'(1);
                            state_q <= MEAS_LOW;
                        end else begin
                            hcnt_q <= hcnt_q + W'(1);
                            pcnt_q <= pcnt_q + W'(1);
                        end
                    end
                    MEAS_LOW: begin
                        if (rise) begin
                            hcnt_q  <= W'(1);
                            pcnt_q  <= W'(1);
                            state_q <= MEAS_HIGH;
                        end else begin
                            pcnt_q <= pcnt_q + W'(1);
                        end
                    end
                    default: state_q <= WAIT_RISE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_state_q    <= DIV_IDLE;
            rem_q          <= '0;
            div_p_q        <= '0;
            h_lat_q        <= '0;
            p_lat_q        <= '0;
            quot_q         <= '0;
            dcnt_q         <= '0;
            duty_q         <= '0;
            high_count_q   <= '0;
            period_count_q <= '0;
            valid_q        <= 1'b0;
            stuck_q        <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (timeout) begin
                div_state_q    <= DIV_IDLE;
                duty_q         <= s_q ? '1 : '0;
                high_count_q   <= s_q ? '1 : '0;
                period_count_q <= '1;
                valid_q        <= 1'b1;
                stuck_q        <= 1'b1;
            end else begin
                if (div_state_q == DIV_RUN) begin
                    if (dcnt_q == DLAST) begin
                        duty_q         <= quot_q;
                        high_count_q   <= h_lat_q;
                        period_count_q <= p_lat_q;
                        valid_q        <= 1'b1;
                        stuck_q        <= 1'b0;
                        div_state_q    <= DIV_IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= {quot_q[R-2:0], qbit};
                        dcnt_q <= dcnt_q + CW'(1);
                    end
                end
                // A latch coinciding with the final step still lets that result publish,
                // so a period of exactly R+1 cycles yields a result.
                if (latch) begin
                    rem_q       <= {1'b0, hcnt_q};
                    div_p_q     <= pcnt_q;
                    h_lat_q     <= hcnt_q;
                    p_lat_q     <= pcnt_q;
                    quot_q      <= '0;
                    dcnt_q      <= '0;
                    div_state_q <= DIV_RUN;
                end
            end
        end
    end

    assign duty         = duty_q;
    assign high_count   = high_count_q;
    assign period_count = period_count_q;
    assign valid        = valid_q;
    assign stuck        = stuck_q;

endmodule
